cal_out_accum: RTL and testbench
================================

Name: cal_out_accum

Overview:
- Downstream consumer of the packed 8-bit add/sub result bus: lane0 = bits[3:0], lane1 = bits[7:4].
- Each lane is interpreted according to the add/sub select that produced it, extended to a signed accumulator width, and summed over a programmable number of samples.
- Each completed per-lane sum is presented on a valid/ready output port.
- Feeds the result-reporting logic that follows the arithmetic datapath.

Parameters:
- NUM_SAMPLES, 8: samples accepted per accumulation window (≥1).
- ACC_W, 10: signed accumulator/output width per lane (≥5).
- CNT_W, $clog2(NUM_SAMPLES+1): width of the sample counter and out_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_cal_out/in_add_sub_sel valid this cycle
- in_ready  output  1  block accepts a sample this cycle
- in_cal_out  input  8  packed result, lane0=[3:0], lane1=[7:4]
- in_add_sub_sel  input  1  select that produced in_cal_out; 0: lane0 is sum, lane1 is difference; 1: swapped
- in_flush  input  1  close the current window early
- out_valid  output  1  out_sum_lane0/1 and out_count valid
- out_ready  input  1  consumer takes the result
- out_sum_lane0  output  ACC_W  signed window sum, lane0
- out_sum_lane1  output  ACC_W  signed window sum, lane1
- out_count  output  CNT_W  samples contained in the presented sums

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) clears everything:
  - state=ACCUM, accumulators=0, count=0.
  - out_valid=0, out_sum_lane0=0, out_sum_lane1=0, out_count=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-window or mid-DONE discards all partial or pending results.
- Lane extension:
  - A lane carrying a sum (range 0..12) is zero-extended.
  - A lane carrying a difference (range -6..6) is 4-bit two's-complement sign-extended.
  - Example: sel=0, in_cal_out=8'hAC gives lane0 = +12 and lane1 = -6.
- Accept: a sample is taken when in_valid && in_ready. in_ready = (state==ACCUM), combinational from state only.
- State ACCUM:
  - On accept, acc_laneN += ext_laneN and count += 1.
  - Window completes on the accept that makes count==NUM_SAMPLES, or when in_flush=1 and (count>0 or an accept occurs this cycle).
  - If in_flush and accept coincide, the sample is included.
  - in_flush with count==0 and no accept is ignored.
  - On completion (registered): out_sum_laneN = final accumulator values, out_count = final count, out_valid=1, state→DONE.
  - Latency: results appear on the cycle after the completing edge.
- State DONE:
  - in_ready=0; outputs held stable while out_valid && !out_ready.
  - On out_ready:
    - out_valid=0 next cycle; accumulators and count cleared; state→ACCUM.
    - out_sum/out_count keep their last values (don't-care once out_valid=0).
  - Inputs are not accepted in the handshake cycle; one bubble cycle exists between windows.
- in_flush in DONE is ignored.
- Arithmetic: two's complement, ACC_W bits per lane. Default build wraps modulo 2^ACC_W on overflow.
- The two lanes are fully independent; no cross-lane interaction.

Optional Feature:
- Macro: CAL_ACC_SAT_EN.
- Defined:
  - Each lane accumulator saturates at +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)).
  - A sticky per-lane overflow bit is kept per window.
  - Added output port out_sat [1:0]: bit0 = lane0, bit1 = lane1. It is registered with the sums, valid with out_valid, and cleared with the accumulators (and on reset).
- Not defined: wrap-around arithmetic; no out_sat port.

Test Plan:
- Reset/idle: assert rst 2 cycles, release → in_ready=1, out_valid=0, sums=0, out_count=0.
- Full window, defaults: 8 samples of in_cal_out=8'hAC, sel=0, in_valid continuous, out_ready=1 → one cycle after 8th accept: out_sum_lane0=96, out_sum_lane1=-48, out_count=8, out_valid=1 for 1 cycle; in_ready low that cycle.
- Select swap: 8 samples of 8'hAC, sel=1 → lane0 = -4×8 = -32, lane1 = 10×8 = 80.
- Backpressure: complete a window with out_ready=0 for 5 cycles → out_valid and outputs held stable, in_ready=0, in_valid samples ignored. Raise out_ready → next cycle out_valid=0, in_ready=1; a following window starts from 0.
- Early flush: 3 accepts of 8'h21 (sel=0), 4th cycle in_flush=1 with in_valid=1 of 8'h21 → out_count=4, lane0=4, lane1=8. A lone flush with count=0 produces no output.
- Overflow: ACC_W=7, 8 samples of lane0 = +12 →
  - Without CAL_ACC_SAT_EN: out_sum_lane0 = 96-128 = -32.
  - With CAL_ACC_SAT_EN: out_sum_lane0 = 63, out_sat[0]=1.
  - Reset asserted mid-window → next window starts clean with out_sat=0.

Source files
------------

// File: rtl/cal_out_accum.sv
// Per-lane windowed accumulator for the packed add/sub result bus, with a valid/ready result port.
// Optional build macro CAL_ACC_SAT_EN: saturating accumulators plus a sticky per-lane out_sat flag.
module cal_out_accum #(
  parameter int NUM_SAMPLES = 8,
  parameter int ACC_W       = 10,
  parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_cal_out,
  input  logic                    in_add_sub_sel,
  input  logic                    in_flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum_lane0,
  output logic signed [ACC_W-1:0] out_sum_lane1,
  output logic [CNT_W-1:0]        out_count
`ifdef CAL_ACC_SAT_EN
  ,
  output logic [1:0]              out_sat
`endif
);

  typedef enum logic {ACCUM, DONE} state_t;

`ifdef CAL_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic signed [ACC_W:0] widen_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    return {a[ACC_W-1], a} + {b[ACC_W-1], b};
  endfunction

  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = widen_add(a, b);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction
`endif

  // Sums (0..12) are unsigned nibbles, differences (-6..6) are two's-complement nibbles.
  function automatic logic signed [ACC_W-1:0] ext_lane(input logic [3:0] nib,
                                                       input logic       is_diff);
    if (is_diff)
      return {{(ACC_W-4){nib[3]}}, nib};
    return {{(ACC_W-4){1'b0}}, nib};
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
`ifdef CAL_ACC_SAT_EN
    logic signed [ACC_W:0] s;
    s = widen_add(a, b);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  state_t                  state, next_state;
  logic                    accept, complete, vld_p1;
  logic signed [ACC_W-1:0] ext0_p0, ext1_p0;
  logic signed [ACC_W-1:0] acc0_p0, acc1_p0, acc0_nxt, acc1_nxt;
  logic [CNT_W-1:0]        cnt_p0, cnt_nxt;
  logic signed [ACC_W-1:0] sum0_p1, sum1_p1;
  logic [CNT_W-1:0]        cnt_p1;
`ifdef CAL_ACC_SAT_EN
  logic [1:0]              ovf_p0, ovf_nxt, sat_p1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   if (complete)  next_state = DONE;
      DONE:    if (out_ready) next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCUM);
    vld_p1   = (state == DONE);
  end

  always_comb begin
    accept   = in_valid && in_ready;
    ext0_p0  = ext_lane(in_cal_out[3:0], in_add_sub_sel);
    ext1_p0  = ext_lane(in_cal_out[7:4], ~in_add_sub_sel);
    acc0_nxt = accept ? acc_add(acc0_p0, ext0_p0) : acc0_p0;
    acc1_nxt = accept ? acc_add(acc1_p0, ext1_p0) : acc1_p0;
    cnt_nxt  = cnt_p0 + CNT_W'(accept);
    // A flush only closes a window that holds at least one sample, counting this cycle's.
    complete = (state == ACCUM) &&
               ((accept && (cnt_nxt == CNT_W'(NUM_SAMPLES))) ||
                (in_flush && ((cnt_p0 != '0) || accept)));
`ifdef CAL_ACC_SAT_EN
    ovf_nxt  = ovf_p0 | {accept && add_ovf(acc1_p0, ext1_p0),
                         accept && add_ovf(acc0_p0, ext0_p0)};
`endif
  end

  // Stage p0 accumulators -> stage p1 presented results
  always_ff @(posedge clk) begin
    if (rst) begin
      acc0_p0 <= '0;
      acc1_p0 <= '0;
      cnt_p0  <= '0;
      sum0_p1 <= '0;
      sum1_p1 <= '0;
      cnt_p1  <= '0;
`ifdef CAL_ACC_SAT_EN
      ovf_p0  <= '0;
      sat_p1  <= '0;
`endif
    end else if (state == DONE) begin
      if (out_ready) begin
        acc0_p0 <= '0;
        acc1_p0 <= '0;
        cnt_p0  <= '0;
`ifdef CAL_ACC_SAT_EN
        ovf_p0  <= '0;
        sat_p1  <= '0;
`endif
      end
    end else begin
      acc0_p0 <= acc0_nxt;
      acc1_p0 <= acc1_nxt;
      cnt_p0  <= cnt_nxt;
`ifdef CAL_ACC_SAT_EN
      ovf_p0  <= ovf_nxt;
`endif
      if (complete) begin
        sum0_p1 <= acc0_nxt;
        sum1_p1 <= acc1_nxt;
        cnt_p1  <= cnt_nxt;
`ifdef CAL_ACC_SAT_EN
        sat_p1  <= ovf_nxt;
`endif
      end
    end
  end

  assign out_valid     = vld_p1;
  assign out_sum_lane0 = sum0_p1;
  assign out_sum_lane1 = sum1_p1;
  assign out_count     = cnt_p1;
`ifdef CAL_ACC_SAT_EN
  assign out_sat       = sat_p1;
`endif

endmodule

// File: tb/tb_cal_out_accum.sv
// Bench for cal_out_accum: directed vector table and corner sequences, then random traffic vs a model.
// Two instances share stimulus: default width (ACC_W=10) and a narrow one (ACC_W=7) for overflow.
module tb_cal_out_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_add_sub_sel, in_flush, out_ready;
  logic [7:0] in_cal_out;

  logic              a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic signed [9:0] a_l0, a_l1;
  logic signed [6:0] b_l0, b_l1;
  logic [3:0]        a_cnt, b_cnt;
`ifdef CAL_ACC_SAT_EN
  logic [1:0]        a_sat, b_sat;
`endif

  cal_out_accum #(.NUM_SAMPLES(8), .ACC_W(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_cal_out(in_cal_out), .in_add_sub_sel(in_add_sub_sel), .in_flush(in_flush),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum_lane0(a_l0), .out_sum_lane1(a_l1), .out_count(a_cnt)
`ifdef CAL_ACC_SAT_EN
    , .out_sat(a_sat)
`endif
  );

  cal_out_accum #(.NUM_SAMPLES(8), .ACC_W(7)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_cal_out(in_cal_out), .in_add_sub_sel(in_add_sub_sel), .in_flush(in_flush),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum_lane0(b_l0), .out_sum_lane1(b_l1), .out_count(b_cnt)
`ifdef CAL_ACC_SAT_EN
    , .out_sat(b_sat)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit v, input logic [7:0] d, input bit s, input bit f, input bit r);
    in_valid = v; in_cal_out = d; in_add_sub_sel = s; in_flush = f; out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lane value from the specification's interpretation rules.
  function automatic int ext(input int nib, input bit is_diff);
    if (is_diff && nib >= 8) return nib - 16;
    return nib;
  endfunction

  // Reference: one accumulation step on a w-bit signed accumulator.
  function automatic int acc_step(input int run, input int x, input int w, inout bit ov);
    int t, hi, lo, m;
    t  = run + x;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
`ifdef CAL_ACC_SAT_EN
    if (t > hi) begin t = hi; ov = 1'b1; end
    if (t < lo) begin t = lo; ov = 1'b1; end
`else
    m = 1 << w;
    if (t > hi) t -= m;
    if (t < lo) t += m;
`endif
    return t;
  endfunction

  typedef struct {
    logic [7:0] cal;
    bit         sel;
    int         exp0;
    int         exp1;
  } vec_t;

  vec_t vecs[5];

  task automatic handshake(input string name);
    drv(0, 8'h00, 0, 0, 1);
    tick();
    chk({name, "_valid_drop"}, a_out_valid, 0);
    chk({name, "_ready_back"}, a_in_ready, 1);
  endtask

  task automatic full_window(input string name, input logic [7:0] cal, input bit sel,
                             input int e0, input int e1);
    for (int i = 0; i < 8; i++) begin
      drv(1, cal, sel, 0, 1);
      tick();
    end
    chk({name, "_valid"}, a_out_valid, 1);
    chk({name, "_in_ready_low"}, a_in_ready, 0);
    chk({name, "_lane0"}, int'(a_l0), e0);
    chk({name, "_lane1"}, int'(a_l1), e1);
    chk({name, "_count"}, a_cnt, 8);
    handshake(name);
  endtask

  // Random-phase model state
  bit pend;
  int ra0, ra1, rb0, rb1, rcnt;
  bit oa0, oa1, ob0, ob1;
  int ea0, ea1, eb0, eb1, ecnt;
  bit [1:0] esa, esb;

  task automatic model_clear();
    ra0 = 0; ra1 = 0; rb0 = 0; rb1 = 0; rcnt = 0;
    oa0 = 0; oa1 = 0; ob0 = 0; ob1 = 0;
  endtask

  initial begin
    vecs[0] = '{8'hAC, 1'b0,  96, -48};
    vecs[1] = '{8'hAC, 1'b1, -32,  80};
    vecs[2] = '{8'h21, 1'b0,   8,  16};
    vecs[3] = '{8'hF6, 1'b1,  48, 120};
    vecs[4] = '{8'h9E, 1'b0, 112, -56};

    drv(0, 8'h00, 0, 0, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_lane0", int'(a_l0), 0);
    chk("rst_lane1", int'(a_l1), 0);
    chk("rst_count", a_cnt, 0);
`ifdef CAL_ACC_SAT_EN
    chk("rst_sat", a_sat, 0);
`endif

    foreach (vecs[k])
      full_window($sformatf("vec%0d", k), vecs[k].cal, vecs[k].sel, vecs[k].exp0, vecs[k].exp1);

    // Backpressure: result held while out_ready is low, input ignored.
    for (int i = 0; i < 8; i++) begin
      drv(1, 8'hAC, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", a_out_valid, 1);
      chk("bp_in_ready", a_in_ready, 0);
      chk("bp_lane0", int'(a_l0), 96);
      chk("bp_lane1", int'(a_l1), -48);
      chk("bp_count", a_cnt, 8);
      drv(1, 8'h33, 1, 1, 0);
      tick();
    end
    handshake("bp");
    full_window("bp_next", 8'h21, 0, 8, 16);

    // Early flush with a coincident sample, then a lone flush on an empty window.
    for (int i = 0; i < 3; i++) begin
      drv(1, 8'h21, 0, 0, 1);
      tick();
    end
    chk("flush_not_yet", a_out_valid, 0);
    drv(1, 8'h21, 0, 1, 1);
    tick();
    chk("flush_valid", a_out_valid, 1);
    chk("flush_count", a_cnt, 4);
    chk("flush_lane0", int'(a_l0), 4);
    chk("flush_lane1", int'(a_l1), 8);
    handshake("flush");
    drv(0, 8'h00, 0, 1, 1);
    tick();
    chk("lone_flush_0", a_out_valid, 0);
    tick();
    chk("lone_flush_1", a_out_valid, 0);

    // Overflow on the narrow instance.
    for (int i = 0; i < 8; i++) begin
      drv(1, 8'h0C, 0, 0, 1);
      tick();
    end
    chk("ovf_valid", b_out_valid, 1);
    chk("ovf_wide_lane0", int'(a_l0), 96);
`ifdef CAL_ACC_SAT_EN
    chk("ovf_lane0", int'(b_l0), 63);
    chk("ovf_sat", b_sat, 2'b01);
    chk("ovf_wide_sat", a_sat, 2'b00);
`else
    chk("ovf_lane0", int'(b_l0), -32);
`endif
    chk("ovf_lane1", int'(b_l1), 0);
    handshake("ovf");
    for (int i = 0; i < 3; i++) begin
      drv(1, 8'h0C, 0, 0, 1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", b_out_valid, 0);
    chk("midrst_ready", b_in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      drv(1, 8'h21, 0, 0, 1);
      tick();
    end
    chk("midrst_lane0", int'(b_l0), 8);
    chk("midrst_lane1", int'(b_l1), 16);
    chk("midrst_count", b_cnt, 8);
`ifdef CAL_ACC_SAT_EN
    chk("midrst_sat", b_sat, 2'b00);
`endif
    handshake("midrst");

    // Random traffic against the reference model.
    pend = 0;
    model_clear();
    ea0 = 0; ea1 = 0; eb0 = 0; eb1 = 0; ecnt = 0; esa = 0; esb = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int n0, n1;
      bit acc_now;
      rst = ($urandom_range(0, 199) == 0);
      drv($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
      if (rst) begin
        pend = 0;
        model_clear();
      end else if (pend) begin
        if (out_ready) begin
          pend = 0;
          model_clear();
        end
      end else begin
        acc_now = in_valid;
        if (acc_now) begin
          n0 = ext(int'(in_cal_out[3:0]), in_add_sub_sel);
          n1 = ext(int'(in_cal_out[7:4]), !in_add_sub_sel);
          ra0 = acc_step(ra0, n0, 10, oa0);
          ra1 = acc_step(ra1, n1, 10, oa1);
          rb0 = acc_step(rb0, n0, 7, ob0);
          rb1 = acc_step(rb1, n1, 7, ob1);
          rcnt++;
        end
        if ((acc_now && rcnt == 8) || (in_flush && rcnt > 0)) begin
          pend = 1;
          ea0 = ra0; ea1 = ra1; eb0 = rb0; eb1 = rb1; ecnt = rcnt;
          esa = {oa1, oa0}; esb = {ob1, ob0};
        end
      end
      tick();
      chk("rnd_a_valid", a_out_valid, pend);
      chk("rnd_b_valid", b_out_valid, pend);
      chk("rnd_a_ready", a_in_ready, !pend);
      if (pend) begin
        chk("rnd_a_lane0", int'(a_l0), ea0);
        chk("rnd_a_lane1", int'(a_l1), ea1);
        chk("rnd_b_lane0", int'(b_l0), eb0);
        chk("rnd_b_lane1", int'(b_l1), eb1);
        chk("rnd_count", a_cnt, ecnt);
`ifdef CAL_ACC_SAT_EN
        chk("rnd_a_sat", a_sat, esa);
        chk("rnd_b_sat", b_sat, esb);
`endif
      end
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
